// File: rtl/sl_pkg.sv
// Shared field positions, FSM states and reset config for the SL receiver.
// Pure declarations; no logic, no latency, no backpressure.
package sl_pkg;

  localparam int CFG_PCE     = 0;
  localparam int CFG_LEN_LSB = 1;
  localparam int CFG_LEN_MSB = 6;
  localparam int CFG_CLR     = 7;

  localparam int ST_LEN_ERR = 0;
  localparam int ST_READY   = 3;
  localparam int ST_PAR_ERR = 4;
  localparam int ST_LVL_ERR = 5;
  localparam int ST_OVF     = 6;
  localparam int ST_CFG_ERR = 7;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_CNT_MSB = 11;

  typedef enum logic [2:0] {IDLE, DATA, STOP, EVAL, LVL} sl_rx_state_t;

  localparam logic [15:0] CFG_RESET = 16'h0010;

  function automatic logic [5:0] cfg_len(input logic [15:0] cfg);
    return cfg[CFG_LEN_MSB:CFG_LEN_LSB];
  endfunction

endpackage

// File: rtl/sl_rx_fifo.sv
// Generic first-word-fall-through sync FIFO; push visible on pop_dat one cycle later.
// Push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module sl_rx_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  typedef logic [PW:0] cnt_t;
  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t             count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + cnt_t'(1);
    else if (!push_ok && pop_ok) count_d = count_q - cnt_t'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat;
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign pop_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/sl_receiver_fifo.sv
// Two-wire SL receiver: pulse decode, parity/length/level checks, words into a FIFO.
// Push visible SYNC_STAGES+2 cycles after the lines return high; drained by rd_valid/rd_ready.
module sl_receiver_fifo
  import sl_pkg::*;
#(
  parameter int MAX_LEN     = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LVL_TIMEOUT = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               serial_line_zeroes_a,
  input  logic               serial_line_ones_a,
  input  logic               wr_enable,
  input  logic [15:0]        wr_config_w,
  output logic [15:0]        r_config_w,
  output logic [15:0]        status_w,
  output logic               data_status_changed,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [MAX_LEN-1:0] rd_data,
  output logic               rd_par_err
);
  localparam int BW = $clog2(MAX_LEN + 2);
  localparam int TW = $clog2(LVL_TIMEOUT + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BCNT_MAX = BW'(MAX_LEN + 1);
  localparam logic [TW-1:0] LO_MAX   = TW'(LVL_TIMEOUT);

  logic [SYNC_STAGES-1:0] zs_q, zs_d, os_q, os_d;
  logic                   zp_q, op_q;
  logic [TW-1:0]          lo_z_q, lo_z_d, lo_o_q, lo_o_d;
  sl_rx_state_t           state_q, state_d;
  logic [BW-1:0]          bcnt_q, bcnt_d;
  logic [MAX_LEN:0]       sh_q, sh_d, pmask;
  logic [MAX_LEN-1:0]     dmask, data_w;
  logic [4:0]             flg_q, flg_d, flg_set;  // {cfg, ovf, lvl, par, len}
  logic [15:0]            cfg_q, cfg_d;
  logic                   dsc_q, dsc_d;

  logic z, o, rise_z, rise_o, fall_any, lvl_hit, wr_bad, cfg_wr_ok, clr;
  logic is_eval, len_bad, par_ok, push;
  logic [MAX_LEN:0]       head;
  logic                   fifo_full, fifo_empty;
  logic [CW-1:0]          fifo_cnt;
  logic                   unused_cfg_hi;

  assign unused_cfg_hi = ^wr_config_w[15:8];

  always_comb begin
    zs_d[0] = serial_line_zeroes_a;
    os_d[0] = serial_line_ones_a;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      zs_d[i] = zs_q[i-1];
      os_d[i] = os_q[i-1];
    end
  end

  assign z        = zs_q[SYNC_STAGES-1];
  assign o        = os_q[SYNC_STAGES-1];
  assign rise_z   = z & ~zp_q;
  assign rise_o   = o & ~op_q;
  assign fall_any = (~z & zp_q) | (~o & op_q);
  assign lo_z_d   = z ? '0 : ((lo_z_q == LO_MAX) ? lo_z_q : lo_z_q + TW'(1));
  assign lo_o_d   = o ? '0 : ((lo_o_q == LO_MAX) ? lo_o_q : lo_o_q + TW'(1));
  assign lvl_hit  = (lo_z_q == LO_MAX) | (lo_o_q == LO_MAX);

  assign wr_bad    = (int'(cfg_len(wr_config_w)) == 0) || (int'(cfg_len(wr_config_w)) > MAX_LEN);
  assign cfg_wr_ok = wr_enable & ~wr_bad;
  assign clr       = wr_enable & wr_config_w[CFG_CLR];
  assign cfg_d     = cfg_wr_ok ? {9'b0, wr_config_w[CFG_LEN_MSB:CFG_PCE]} : cfg_q;

  // Frame word holds LEN data bits followed by the parity bit at position LEN.
  always_comb begin
    for (int i = 0; i <= MAX_LEN; i++) pmask[i] = (i <= int'(cfg_len(cfg_q)));
    for (int i = 0; i < MAX_LEN; i++)  dmask[i] = (i < int'(cfg_len(cfg_q)));
  end

  assign data_w  = sh_q[MAX_LEN-1:0] & dmask;
  assign par_ok  = ^(sh_q & pmask);
  assign is_eval = (state_q == EVAL);
  assign len_bad = is_eval & (int'(bcnt_q) != int'(cfg_len(cfg_q)) + 1);
  assign push    = is_eval & ~len_bad & (par_ok | ~cfg_q[CFG_PCE]);

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: if (fall_any) begin
        state_d = DATA;
        bcnt_d  = '0;
        sh_d    = '0;
      end
      DATA: begin
        if (!z && !o) begin
          state_d = STOP;
        end else if (rise_z ^ rise_o) begin
          if (bcnt_q != BCNT_MAX) begin
            sh_d[bcnt_q] = rise_o;
            bcnt_d       = bcnt_q + BW'(1);
          end
        end
      end
      STOP:    if (z && o) state_d = EVAL;
      EVAL:    state_d = IDLE;
      LVL:     if (z && o) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (lvl_hit && state_q != LVL) state_d = LVL;
    if (cfg_wr_ok) state_d = IDLE;
  end

  always_comb begin
    flg_set    = '0;
    flg_set[0] = len_bad;
    flg_set[1] = is_eval & ~len_bad & ~par_ok;
    flg_set[2] = lvl_hit & (state_q != LVL) & ~cfg_wr_ok;
    flg_set[3] = push & fifo_full & ~rd_ready;
    flg_set[4] = wr_enable & wr_bad;
    // A flag raised in the same cycle as a clear survives it.
    flg_d      = (clr ? 5'b0 : flg_q) | flg_set;
    dsc_d      = push | (|(flg_d & ~flg_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zs_q    <= '1;
      os_q    <= '1;
      zp_q    <= 1'b1;
      op_q    <= 1'b1;
      lo_z_q  <= '0;
      lo_o_q  <= '0;
      state_q <= IDLE;
      bcnt_q  <= '0;
      sh_q    <= '0;
      flg_q   <= '0;
      cfg_q   <= CFG_RESET;
      dsc_q   <= 1'b0;
    end else begin
      zs_q    <= zs_d;
      os_q    <= os_d;
      zp_q    <= z;
      op_q    <= o;
      lo_z_q  <= lo_z_d;
      lo_o_q  <= lo_o_d;
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      flg_q   <= flg_d;
      cfg_q   <= cfg_d;
      dsc_q   <= dsc_d;
    end
  end

  sl_rx_fifo #(.WIDTH(MAX_LEN + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat ({~par_ok, data_w}),
    .pop      (rd_ready),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  assign rd_valid            = ~fifo_empty;
  assign rd_data             = rd_valid ? head[MAX_LEN-1:0] : '0;
  assign rd_par_err          = rd_valid & head[MAX_LEN];
  assign r_config_w          = cfg_q;
  assign data_status_changed = dsc_q;

  always_comb begin
    status_w             = '0;
    status_w[ST_LEN_ERR] = flg_q[0];
    status_w[ST_READY]   = rd_valid;
    status_w[ST_PAR_ERR] = flg_q[1];
    status_w[ST_LVL_ERR] = flg_q[2];
    status_w[ST_OVF]     = flg_q[3];
    status_w[ST_CFG_ERR] = flg_q[4];
    status_w[ST_CNT_MSB:ST_CNT_LSB] = (int'(fifo_cnt) > 15) ? 4'hF : 4'(fifo_cnt);
  end

endmodule

// File: doc/sl_receiver_fifo.md
Name: sl_receiver_fifo

Overview:
Second-generation two-wire SL (serial line) receiver. Decodes pulse-encoded frames on the zeroes/ones lines and supports configurable word length up to MAX_LEN, optional parity check and level-error timeout. Accepted words go into a FIFO_DEPTH-deep receive FIFO drained by a valid/ready handshake, replacing the single-word word_picked register. Sits between the SL line pins and the host register bus.

Parameters:
MAX_LEN, 32, maximum data bits per frame (8..32); rd_data width
FIFO_DEPTH, 4, receive FIFO entries (power of two, 2..16)
SYNC_STAGES, 2, synchroniser flops per line input
LVL_TIMEOUT, 256, clk cycles a line may stay low before a level error is raised

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
serial_line_zeroes_a  in  1  async SL zeroes line, idle high
serial_line_ones_a  in  1  async SL ones line, idle high
wr_enable  in  1  one-cycle strobe; loads wr_config_w
wr_config_w  in  16  [0] PCE, [6:1] LEN, [7] clear sticky flags (self-clearing, not stored)
r_config_w  out  16  current config: [0] PCE, [6:1] LEN, others 0
status_w  out  16  [0] len_err, [3] word_ready, [4] par_err, [5] lvl_err, [6] overflow, [7] cfg_err, [11:8] FIFO count, others 0
data_status_changed  out  1  one-cycle pulse on any FIFO push or any sticky-flag 0->1
rd_valid  out  1  FIFO non-empty
rd_ready  in  1  pop head when rd_valid and rd_ready both high
rd_data  out  MAX_LEN  head word, LSB = first received bit, bits >= LEN are zero
rd_par_err  out  1  head word was received with a parity mismatch (PCE=0 only)

Behaviour:
- Reset: r_config_w = LEN 8, PCE 0 (16'h0010). status_w = 0, rd_valid = 0, rd_data = 0, rd_par_err = 0, data_status_changed = 0. FIFO empty, FSM in IDLE.
- Frame format: idle both lines high.
  - Data bit 0 is a low pulse on zeroes; data bit 1 is a low pulse on ones. Bits are sent LSB first.
  - After LEN data bits comes one parity pulse, P = ~XOR(data bits) (odd parity over data+P), encoded the same way.
  - Stop is both lines low in the same synchronised sample.
- Decoding: inputs pass through SYNC_STAGES flops. A bit is recorded on the synchronised rising edge of a single line.
- Bit index counter: saturates at MAX_LEN+1; bit i is written to shift position i.
- FSM states:
  - IDLE -> DATA on the first line falling edge.
  - DATA -> STOP when both lines are low.
  - STOP -> EVAL when both lines are high.
  - EVAL -> IDLE after one cycle.
  - Any state -> LVL when either line has been continuously low for LVL_TIMEOUT cycles.
  - LVL -> IDLE when both lines are high.
- EVAL checks, in this order:
  - count != LEN+1: set len_err, no push.
  - Else parity mismatch and PCE=1: set par_err, no push.
  - Else parity mismatch and PCE=0: set par_err and push with rd_par_err=1.
  - Else push with rd_par_err=0.
- Latency: push is visible (rd_valid, count) 1 cycle after EVAL, i.e. SYNC_STAGES+2 cycles after both lines return high.
- LVL: sets lvl_err and discards the frame in progress. The FIFO is untouched.
- Rising edges while in STOP or LVL are ignored.
- Config write:
  - Takes effect the next cycle and forces the FSM to IDLE, discarding any partial frame.
  - LEN = 0 or LEN > MAX_LEN: write ignored and cfg_err set.
  - Bit 7 clears len_err, par_err, lvl_err, overflow and cfg_err. A flag set in the same cycle as the clear wins (ends set).
- FIFO: first-word-fall-through.
  - Push when full with no pop: word dropped, overflow set.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Pop when empty: ignored.
  - word_ready = rd_valid.
  - Count saturates at 15 in the status field.
- Reset mid-frame or mid-pop: all state clears immediately (asynchronous).

Decomposition:
- Package sl_pkg holds:
  - config field positions (CFG_PCE, CFG_LEN_LSB/MSB, CFG_CLR);
  - status bit positions (ST_LEN_ERR, ST_READY, ST_PAR_ERR, ST_LVL_ERR, ST_OVF, ST_CFG_ERR, ST_CNT_LSB/MSB);
  - FSM enum sl_rx_state_t {IDLE, DATA, STOP, EVAL, LVL};
  - reset config constant.
- One sub-module, sl_rx_fifo: parametrised sync FIFO, width MAX_LEN+1, depth FIFO_DEPTH, with push/pop/full/empty/count.

Test Plan:
1. Config LEN=8, PCE=1; send 0xA5 with correct parity, rd_ready=0 -> rd_valid=1, rd_data=0xA5, status_w=16'h0108.
2. LEN=32, PCE=0; send 0xDEADBEEF then pop -> rd_data=0xDEADBEEF, rd_par_err=0; after pop rd_valid=0, status_w=0.
3. LEN=8, rd_ready=0; send 5 correct frames -> count=4, overflow=1, head = first word. Drain 4 pops in order; then write config with bit 7 -> status_w=0.
4. LEN=8, PCE=1, wrong parity -> no push, par_err=1. Same with PCE=0 -> push with rd_par_err=1. A 10-bit frame -> len_err=1, no push.
5. Hold zeroes low for LVL_TIMEOUT+20 cycles mid-frame -> lvl_err=1, no push, data_status_changed pulses once. Next correct frame is accepted.
6. FIFO holding 2 words, assert rst_n=0 mid-frame -> rd_valid=0 and status_w=0 immediately. After release, a correct frame decodes normally.
